// File: rtl/lr35902_sio_pkg.sv
// Shared constants and types for the LR35902 serial link port.
package lr35902_sio_pkg;

  localparam logic        SIO_ADR_SB = 1'b1;
  localparam logic        SIO_ADR_SC = 1'b0;

  localparam int unsigned SC_START  = 7;
  localparam int unsigned SC_CLKSEL = 0;
  localparam logic [5:0]  SC_FILL   = 6'h3f;

  localparam int unsigned SIO_CLK_DIV_DEFAULT = 512;

  typedef enum logic {
    SIO_IDLE = 1'b0,
    SIO_XFER = 1'b1
  } sio_state_t;

endpackage

// File: rtl/lr35902_sio_link_if.sv
// CPU-side register bus of the serial link port.
interface lr35902_sio_link_if;
  logic [7:0] dout;
  logic [7:0] din;
  logic       adr;
  logic       write;
  logic       irq;

  modport master (output din, output adr, output write, input dout, input irq);
  modport slave  (input din, input adr, input write, output dout, output irq);
endinterface

// File: rtl/lr35902_sio_sync.sv
// Multi-stage synchronizer with registered-history edge pulses; idles high.
module lr35902_sio_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic              prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr   <= '1;
      prev <= 1'b1;
    end else begin
      sr   <= (sr << 1) | STAGES'(d);
      prev <= sr[STAGES-1];
    end
  end

  assign rise = sr[STAGES-1] && !prev;
  assign fall = !sr[STAGES-1] && prev;
endmodule

// File: rtl/lr35902_sio_link.sv
// LR35902 serial link: SB/SC registers, internal/external clocked 8-bit shifter.
module lr35902_sio_link
  import lr35902_sio_pkg::*;
#(
  parameter int unsigned CLK_DIV     = SIO_CLK_DIV_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  lr35902_sio_link_if.slave bus,
  input  logic              sck_in,
  output logic              sck_out,
  output logic              sck_oe,
  input  logic              sin,
  output logic              sout
);
  localparam int unsigned   PW          = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST     = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HALF     = PW'(CLK_DIV / 2);
  localparam logic [PW-1:0] PH_PRE_RISE = PW'(CLK_DIV / 2 - 1);

  sio_state_t             state;
  logic [7:0]             sb;
  logic                   sclk;
  logic                   pwrite;
  logic [3:0]             bit_count;
  logic [PW-1:0]          phase;
  logic [SYNC_STAGES-1:0] sin_sr;

  logic       sck_rise, sck_fall;
  logic       tstart, int_mode, ext_mode;
  logic       rise_ev, fall_ev, done, busy, commit;
  logic [7:0] sb_next;

  lr35902_sio_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sck_in),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  assign tstart   = (state == SIO_XFER);
  assign int_mode = tstart && sclk;
  assign ext_mode = tstart && !sclk;
  assign rise_ev  = int_mode ? (phase == PH_PRE_RISE) : (ext_mode && sck_rise);
  assign fall_ev  = int_mode ? (phase == PH_LAST)     : (ext_mode && sck_fall);
  assign sb_next  = rise_ev ? {sb[6:0], sin_sr[SYNC_STAGES-1]} : sb;
  assign done     = rise_ev && (bit_count == 4'd7);
  // A completing transfer counts as idle for an SC write landing in the same clk.
  assign busy     = tstart && !done;
  assign commit   = pwrite && !bus.write;

  assign sck_oe  = sclk;
  assign sck_out = !(int_mode && (phase < PH_HALF));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SIO_IDLE;
      sb        <= '0;
      sclk      <= 1'b0;
      bit_count <= '0;
      phase     <= '0;
      pwrite    <= 1'b0;
      sin_sr    <= '1;
      bus.dout  <= '0;
      bus.irq   <= 1'b0;
      sout      <= 1'b1;
    end else begin
      pwrite   <= bus.write;
      sin_sr   <= (sin_sr << 1) | SYNC_STAGES'(sin);
      bus.dout <= (bus.adr == SIO_ADR_SB) ? sb : {tstart, SC_FILL, sclk};
      bus.irq  <= 1'b0;
      sb       <= sb_next;

      if (int_mode) phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      if (rise_ev) bit_count <= bit_count + 4'd1;
      // The first falling edge precedes any shift, so sout already holds sb[7].
      if (fall_ev && (bit_count != 4'd0)) sout <= sb[7];

      if (done) begin
        state   <= SIO_IDLE;
        bus.irq <= 1'b1;
      end

      if (commit) begin
        if (bus.adr == SIO_ADR_SB) begin
          if (!busy) sb <= bus.din;
        end else begin
          sclk <= bus.din[SC_CLKSEL];
          if (bus.din[SC_START]) begin
            phase <= '0;
            if (!busy) begin
              state     <= SIO_XFER;
              bit_count <= '0;
              sout      <= sb_next[7];
            end
          end else if (busy) begin
            state <= SIO_IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_lr35902_sio_link.sv
// Directed self-checking bench for lr35902_sio_link with CLK_DIV=8.
module tb_lr35902_sio_link;
  logic clk;
  logic reset;
  logic sck_in, sck_out, sck_oe, sin, sout;
  int   checks, failures;

  lr35902_sio_link_if bus ();

  lr35902_sio_link #(.CLK_DIV(8), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .sck_in (sck_in),
    .sck_out(sck_out),
    .sck_oe (sck_oe),
    .sin    (sin),
    .sout   (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic a, input logic [7:0] d);
    bus.adr = a; bus.din = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic a, output logic [7:0] v);
    bus.adr = a;
    @(negedge clk);
    v = bus.dout;
  endtask

  // Partner drives sin MSB-first on its falling edge and samples sout on its rising edge.
  task automatic run_ext(input logic [7:0] data, input int wr_cyc, input logic wr_adr,
                         input logic [7:0] wr_din, output logic [7:0] prx,
                         output int irqs, output int oe_bad);
    prx = '0; irqs = 0; oe_bad = 0;
    for (int c = 0; c < 160; c++) begin
      if (bus.irq === 1'b1) irqs++;
      if (sck_oe !== 1'b0) oe_bad++;
      if (c < 128) begin
        if (c % 16 == 0) begin
          sck_in = 1'b0;
          sin    = data[7 - c / 16];
        end else if (c % 16 == 8) begin
          sck_in = 1'b1;
          prx    = {prx[6:0], sout};
        end
      end
      if (c == wr_cyc) begin
        bus.adr = wr_adr; bus.din = wr_din; bus.write = 1'b1;
      end else begin
        bus.write = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b0; sck_in = 1'b1; sin = 1'b1;
    bus.adr = 1'b0; bus.din = '0; bus.write = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.dout !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h expected 00", bus.dout); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
    checks++; if (sck_out !== 1'b1) begin failures++; $display("FAIL reset_sck_out: got %b expected 1", sck_out); end
    checks++; if (sout !== 1'b1) begin failures++; $display("FAIL reset_sout: got %b expected 1", sout); end
    checks++; if (sck_oe !== 1'b0) begin failures++; $display("FAIL reset_sck_oe: got %b expected 0", sck_oe); end
    reset = 1'b1;
    @(negedge clk);
    bus_read(1'b0, v);
    checks++; if (v !== 8'h7E) begin failures++; $display("FAIL reset_sc: got %h expected 7e", v); end
    bus_read(1'b1, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_sb: got %h expected 00", v); end
  endtask

  task automatic test_internal();
    int lows, run, bad_len, irqs;
    logic [7:0] bits, v;
    sin = 1'b1;
    bus_write(1'b1, 8'hA5);
    bus_write(1'b0, 8'h81);
    checks++; if (sck_oe !== 1'b1) begin failures++; $display("FAIL int_sck_oe: got %b expected 1", sck_oe); end
    lows = 0; run = 0; bad_len = 0; irqs = 0; bits = '0;
    for (int c = 0; c < 100; c++) begin
      if (bus.irq === 1'b1) irqs++;
      if (sck_out === 1'b0) begin
        if (run == 0) begin lows++; bits = {bits[6:0], sout}; end
        run++;
      end else begin
        if (run != 0 && run != 4) bad_len++;
        run = 0;
      end
      @(negedge clk);
    end
    checks++; if (lows !== 8) begin failures++; $display("FAIL int_low_pulses: got %0d expected 8", lows); end
    checks++; if (bad_len !== 0) begin failures++; $display("FAIL int_pulse_len: got %0d bad pulses expected 0", bad_len); end
    checks++; if (bits !== 8'hA5) begin failures++; $display("FAIL int_sout_bits: got %h expected a5", bits); end
    checks++; if (irqs !== 1) begin failures++; $display("FAIL int_irq_count: got %0d expected 1", irqs); end
    bus_read(1'b1, v);
    checks++; if (v !== 8'hFF) begin failures++; $display("FAIL int_sb: got %h expected ff", v); end
    bus_read(1'b0, v);
    checks++; if (v !== 8'h7F) begin failures++; $display("FAIL int_sc: got %h expected 7f", v); end
  endtask

  task automatic test_external();
    logic [7:0] prx, v;
    int irqs, oe_bad;
    bus_write(1'b1, 8'h3C);
    bus_write(1'b0, 8'h80);
    run_ext(8'hC3, -1, 1'b0, 8'h00, prx, irqs, oe_bad);
    checks++; if (prx !== 8'h3C) begin failures++; $display("FAIL ext_partner_rx: got %h expected 3c", prx); end
    checks++; if (irqs !== 1) begin failures++; $display("FAIL ext_irq_count: got %0d expected 1", irqs); end
    checks++; if (oe_bad !== 0) begin failures++; $display("FAIL ext_sck_oe: got %0d cycles high expected 0", oe_bad); end
    bus_read(1'b1, v);
    checks++; if (v !== 8'hC3) begin failures++; $display("FAIL ext_sb: got %h expected c3", v); end
  endtask

  // Abort lands after four rising edges; later partner edges must not shift SB.
  task automatic test_abort();
    logic [7:0] prx, v;
    int irqs, oe_bad;
    bus_write(1'b1, 8'h00);
    bus_write(1'b0, 8'h80);
    run_ext(8'hB0, 66, 1'b0, 8'h00, prx, irqs, oe_bad);
    checks++; if (irqs !== 0) begin failures++; $display("FAIL abort_irq: got %0d expected 0", irqs); end
    bus_read(1'b0, v);
    checks++; if (v !== 8'h7E) begin failures++; $display("FAIL abort_sc: got %h expected 7e", v); end
    bus_read(1'b1, v);
    checks++; if (v !== 8'h0B) begin failures++; $display("FAIL abort_sb: got %h expected 0b", v); end
  endtask

  task automatic test_sb_write_busy();
    logic [7:0] prx, v;
    int irqs, oe_bad;
    bus_write(1'b1, 8'h00);
    bus_write(1'b0, 8'h80);
    run_ext(8'h96, 40, 1'b1, 8'h55, prx, irqs, oe_bad);
    checks++; if (irqs !== 1) begin failures++; $display("FAIL sbw_irq: got %0d expected 1", irqs); end
    bus_read(1'b1, v);
    checks++; if (v !== 8'h96) begin failures++; $display("FAIL sbw_sb: got %h expected 96", v); end
  endtask

  // Second SC write commits on the same clk as the 8th internal rising edge (start+60).
  task automatic test_back_to_back();
    int irqs;
    sin = 1'b1;
    bus_write(1'b1, 8'h00);
    bus_write(1'b0, 8'h81);
    repeat (58) @(negedge clk);
    bus.adr = 1'b0; bus.din = 8'h81; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL b2b_irq_early: got %b expected 0", bus.irq); end
    @(negedge clk);
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL b2b_irq: got %b expected 1", bus.irq); end
    checks++; if (sck_out !== 1'b0) begin failures++; $display("FAIL b2b_sck_low: got %b expected 0", sck_out); end
    @(negedge clk);
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL b2b_irq_width: got %b expected 0", bus.irq); end
    checks++; if (bus.dout !== 8'hFF) begin failures++; $display("FAIL b2b_sc_busy: got %h expected ff", bus.dout); end
    irqs = 0;
    for (int c = 0; c < 80; c++) begin
      if (bus.irq === 1'b1) irqs++;
      @(negedge clk);
    end
    checks++; if (irqs !== 1) begin failures++; $display("FAIL b2b_second_irq: got %0d expected 1", irqs); end
  endtask

  task automatic test_reset_mid();
    int irqs, sck_bad;
    logic [7:0] v;
    sin = 1'b1;
    bus_write(1'b1, 8'h5A);
    bus_write(1'b0, 8'h81);
    bus.adr = 1'b1;
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.dout !== 8'h00) begin failures++; $display("FAIL rstm_dout: got %h expected 00", bus.dout); end
    checks++; if (sck_out !== 1'b1) begin failures++; $display("FAIL rstm_sck_out: got %b expected 1", sck_out); end
    checks++; if (sout !== 1'b1) begin failures++; $display("FAIL rstm_sout: got %b expected 1", sout); end
    checks++; if (sck_oe !== 1'b0) begin failures++; $display("FAIL rstm_sck_oe: got %b expected 0", sck_oe); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    irqs = 0; sck_bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.irq === 1'b1) irqs++;
      if (sck_out !== 1'b1) sck_bad++;
      @(negedge clk);
    end
    checks++; if (irqs !== 0) begin failures++; $display("FAIL rstm_irq: got %0d expected 0", irqs); end
    checks++; if (sck_bad !== 0) begin failures++; $display("FAIL rstm_sck_idle: got %0d low cycles expected 0", sck_bad); end
    bus_read(1'b0, v);
    checks++; if (v !== 8'h7E) begin failures++; $display("FAIL rstm_sc: got %h expected 7e", v); end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_internal();
    test_external();
    test_abort();
    test_sb_write_busy();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
